// File: rtl/digit_pkg.sv
// Shared definitions for the sequential decimal-digit unit: op codes, FSM states
// and constant helpers for range and latency.
package digit_pkg;

    localparam logic OP_DGT = 1'b0;
    localparam logic OP_DST = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        MOD,
        BUILD,
        DONE
    } state_t;

    // Largest magnitude representable with ndig decimal digits.
    function automatic int dmax(input int ndig);
        int v = 1;
        for (int i = 0; i < ndig; i++) v = v * 10;
        return v - 1;
    endfunction

    function automatic int lat(input int w, input int ndig);
        return w + ndig + 2;
    endfunction

endpackage

// File: rtl/digit_unit_seq_if.sv
// Request/response bundle between the instruction sequencer and the digit unit.
interface digit_unit_seq_if #(
    parameter int W = 11
);
    logic                start;
    logic                clr;
    logic                op;
    logic signed [W-1:0] acc;
    logic signed [W-1:0] arg1;
    logic signed [W-1:0] arg2;
    logic                ready;
    logic                done;
    logic signed [W-1:0] out;

    modport master (
        output start, clr, op, acc, arg1, arg2,
        input  ready, done, out
    );

    modport slave (
        input  start, clr, op, acc, arg1, arg2,
        output ready, done, out
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift-add-3 step per cycle, W steps
// after a load pulse; valid stays high until the next load.
module bin2bcd_seq #(
    parameter int W    = 11,
    parameter int NDIG = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [W-1:0]      mag,
    output logic [4*NDIG-1:0] bcd,
    output logic              valid
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  bin_q;
    logic [CW-1:0] cnt_q;

    function automatic logic [4*NDIG-1:0] add3(input logic [4*NDIG-1:0] v);
        logic [4*NDIG-1:0] r = v;
        for (int k = 0; k < NDIG; k++)
            if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd   <= '0;
            cnt_q <= '0;
            valid <= 1'b0;
        end else if (load) begin
            bin_q <= mag;
            bcd   <= '0;
            cnt_q <= '0;
            valid <= 1'b0;
        end else if (cnt_q != CW'(W)) begin
            {bcd, bin_q} <= {add3(bcd), bin_q} << 1;
            cnt_q        <= cnt_q + CW'(1);
            valid        <= (cnt_q == CW'(W - 1));
        end
    end

endmodule

// File: rtl/digit_unit_seq.sv
// Multi-cycle DGT/DST digit unit: clamp, convert to BCD, optionally replace one
// digit, rebuild the binary magnitude MS digit first, then apply the sign.
module digit_unit_seq
    import digit_pkg::*;
#(
    parameter int NDIG = 3,
    parameter int W    = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    digit_unit_seq_if.slave bus
);
    localparam int DMAX = dmax(NDIG);
    localparam int CW   = $clog2(W + 1);
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int BW   = 4 * NDIG;
    localparam logic signed [W-1:0] DMAX_S = W'(DMAX);
    localparam logic signed [W-1:0] NDIG_S = W'(NDIG);

    function automatic logic signed [W-1:0] clamp_acc(input logic signed [W-1:0] a);
        if (a > DMAX_S)  return DMAX_S;
        if (a < -DMAX_S) return -DMAX_S;
        return a;
    endfunction

    // Magnitude is formed one bit wider so the most negative input cannot wrap.
    function automatic logic [3:0] sat_digit(input logic signed [W-1:0] a);
        logic signed [W:0] ax;
        ax = (W + 1)'(a);
        if (ax[W]) ax = -ax;
        return (ax > (W + 1)'(9)) ? 4'd9 : ax[3:0];
    endfunction

    function automatic logic [3:0] get_digit(input logic [BW-1:0] v, input int i);
        logic [3:0] d = 4'd0;
        for (int k = 0; k < NDIG; k++)
            if (k == i) d = v[4*k +: 4];
        return d;
    endfunction

    function automatic logic [BW-1:0] set_digit(input logic [BW-1:0] v, input int i,
                                                input logic [3:0] d);
        logic [BW-1:0] r = v;
        for (int k = 0; k < NDIG; k++)
            if (k == i) r[4*k +: 4] = d;
        return r;
    endfunction

    state_t              state;
    logic [CW-1:0]       cnt_q;
    logic                op_q, idx_ok_q, s_q, neg_q;
    logic [IW-1:0]       idx_q;
    logic [3:0]          nd_q;
    logic signed [W-1:0] cacc_q;
    logic [BW-1:0]       digs_q;
    logic [W-1:0]        r_q;
    logic [BW-1:0]       bcd;
    logic                bcd_valid;
    logic                accept;
    logic signed [W-1:0] acc_c, res_c, dg_c;
    logic [W-1:0]        mag_c;

    assign accept = (state == IDLE) && bus.start && !bus.clr;
    assign acc_c  = clamp_acc(bus.acc);
    assign mag_c  = acc_c[W-1] ? $unsigned(-acc_c) : $unsigned(acc_c);

    bin2bcd_seq #(.W(W), .NDIG(NDIG)) u_conv (
        .clk  (clk),
        .rst_n(rst_n),
        .load (accept),
        .mag  (mag_c),
        .bcd  (bcd),
        .valid(bcd_valid)
    );

    always_comb begin
        dg_c  = W'(get_digit(digs_q, int'(idx_q)));
        res_c = '0;
        if (op_q == OP_DGT) begin
            if (idx_ok_q) res_c = s_q ? -dg_c : dg_c;
        end else if (!idx_ok_q) begin
            res_c = cacc_q;
        end else if (r_q != '0) begin
            res_c = neg_q ? -$signed(r_q) : $signed(r_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt_q     <= '0;
            op_q      <= OP_DGT;
            idx_ok_q  <= 1'b0;
            s_q       <= 1'b0;
            neg_q     <= 1'b0;
            idx_q     <= '0;
            nd_q      <= '0;
            cacc_q    <= '0;
            digs_q    <= '0;
            r_q       <= '0;
            bus.ready <= 1'b1;
            bus.done  <= 1'b0;
            bus.out   <= '0;
        end else if (bus.clr) begin
            state     <= IDLE;
            cnt_q     <= '0;
            bus.ready <= 1'b1;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    op_q      <= bus.op;
                    idx_ok_q  <= !bus.arg1[W-1] && (bus.arg1 < NDIG_S);
                    idx_q     <= bus.arg1[IW-1:0];
                    nd_q      <= sat_digit(bus.arg2);
                    s_q       <= bus.acc[W-1];
                    neg_q     <= bus.arg2[W-1] || ((bus.arg2 == '0) && bus.acc[W-1]);
                    cacc_q    <= acc_c;
                    cnt_q     <= '0;
                    bus.ready <= 1'b0;
                    state     <= CONV;
                end
                CONV: begin
                    if (cnt_q == CW'(W - 1)) begin
                        cnt_q <= '0;
                        state <= MOD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                MOD: if (bcd_valid) begin
                    digs_q <= (op_q == OP_DST && idx_ok_q) ?
                              set_digit(bcd, int'(idx_q), nd_q) : bcd;
                    r_q    <= '0;
                    state  <= BUILD;
                end
                // r*10 as two shifts; the rebuilt value never exceeds DMAX.
                BUILD: begin
                    r_q <= (r_q << 3) + (r_q << 1) +
                           W'(get_digit(digs_q, NDIG - 1 - int'(cnt_q)));
                    if (cnt_q == CW'(NDIG - 1)) begin
                        cnt_q <= '0;
                        state <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    bus.out   <= res_c;
                    bus.done  <= 1'b1;
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_unit_seq.sv
// Bench for digit_unit_seq: vector table plus hand-written control sequences,
// with a scoreboard queue checked whenever done pulses.
module tb_digit_unit_seq;
    import digit_pkg::*;

    localparam int NDIG = 3;
    localparam int W    = 11;
    localparam int LAT  = 16;
    localparam int NV   = 16;

    typedef struct {
        logic  op;
        int    acc;
        int    arg1;
        int    arg2;
        int    exp;
        string name;
    } vec_t;

    typedef struct {
        int    exp;
        int    acc_cyc;
        string name;
    } sb_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    int    cyc   = 0;
    int    errors = 0;
    int    checks = 0;
    sb_t   sb[$];
    vec_t  vecs[NV];

    digit_unit_seq_if #(.W(W)) bus();

    digit_unit_seq #(.NDIG(NDIG), .W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: done=1 with no pending request, expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check({"out_", e.name}, int'(bus.out), e.exp);
                    check({"lat_", e.name}, cyc - e.acc_cyc, LAT);
                    check({"rdy_", e.name}, int'(bus.ready), 1);
                end
            end
        end
    endtask

    // Caller is positioned at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic op, input int acc, input int arg1, input int arg2,
                         input int exp, input string name);
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout_%s: ready=0, expected 1 within 100 cycles", name);
            return;
        end
        bus.op    = op;
        bus.acc   = W'(acc);
        bus.arg1  = W'(arg1);
        bus.arg2  = W'(arg2);
        bus.start = 1'b1;
        sb.push_back('{exp, cyc + 1, name});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic drop_last();
        if (sb.size() > 0) sb.delete(sb.size() - 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.clr   = 1'b0;
        bus.op    = OP_DGT;
        bus.acc   = '0;
        bus.arg1  = '0;
        bus.arg2  = '0;

        vecs[0]  = '{OP_DST,   123,  1,     7,   173, "dst_123_d1_7"};
        vecs[1]  = '{OP_DGT,  -456,  2,     0,    -4, "dgt_m456_d2"};
        vecs[2]  = '{OP_DGT,  -456,  0,     0,    -6, "dgt_m456_d0"};
        vecs[3]  = '{OP_DST,    50,  0,    -3,   -53, "dst_50_neg_digit"};
        vecs[4]  = '{OP_DST,   -50,  0,     3,    53, "dst_m50_pos_digit"};
        vecs[5]  = '{OP_DST,   -50,  1,     0,     0, "dst_m50_to_zero"};
        vecs[6]  = '{OP_DST,     5,  2,    12,   905, "dst_sat_digit"};
        vecs[7]  = '{OP_DGT,  1023,  0,     0,     9, "dgt_clamp_hi"};
        vecs[8]  = '{OP_DST,   999,  3,     5,   999, "dst_bad_idx"};
        vecs[9]  = '{OP_DGT,   123, -1,     0,     0, "dgt_neg_idx"};
        vecs[10] = '{OP_DST,  -999,  0,     0,  -990, "dst_m999_keep_sign"};
        vecs[11] = '{OP_DGT, -1024,  1,     0,    -9, "dgt_clamp_lo"};
        vecs[12] = '{OP_DST, -1024,  3,     4,  -999, "dst_bad_idx_clamp"};
        vecs[13] = '{OP_DST,     7,  0, -1024,    -9, "dst_min_arg2"};
        vecs[14] = '{OP_DGT,   456,  3,     0,     0, "dgt_idx_ndig"};
        vecs[15] = '{OP_DST,     0,  0,     0,     0, "dst_all_zero"};

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_ready", int'(bus.ready), 1);
        check("rst_done", int'(bus.done), 0);
        check("rst_out", int'(bus.out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].acc, vecs[i].arg1, vecs[i].arg2, vecs[i].exp, vecs[i].name);
            wait_drain();
        end

        // A start four cycles into a busy operation must be dropped.
        issue(OP_DST, 123, 1, 7, 173, "busy_first");
        repeat (3) @(negedge clk);
        check("busy_ready", int'(bus.ready), 0);
        bus.op    = OP_DGT;
        bus.acc   = W'(999);
        bus.arg1  = '0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        repeat (20) @(negedge clk);

        // Second request issued in the done cycle of the first.
        issue(OP_DGT, -456, 0, 0, -6, "b2b_first");
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_seen", int'(bus.done), 1);
        issue(OP_DST, 50, 0, -3, -53, "b2b_second");
        wait_drain();

        // Abort seven cycles after accept.
        issue(OP_DGT, 1023, 0, 0, 9, "clr_victim");
        repeat (6) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check("clr_ready", int'(bus.ready), 1);
        check("clr_done", int'(bus.done), 0);
        check("clr_out_held", int'(bus.out), -53);
        drop_last();
        repeat (25) @(negedge clk);

        // clr wins over a simultaneous start.
        bus.op    = OP_DST;
        bus.acc   = W'(123);
        bus.arg1  = W'(1);
        bus.arg2  = W'(7);
        bus.start = 1'b1;
        bus.clr   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.clr   = 1'b0;
        check("clr_start_ready", int'(bus.ready), 1);
        check("clr_start_done", int'(bus.done), 0);
        repeat (25) @(negedge clk);
        check("clr_start_out_held", int'(bus.out), -53);

        // Asynchronous reset in the middle of an operation.
        issue(OP_DST, 123, 1, 7, 173, "rst_victim");
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", int'(bus.ready), 1);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_out", int'(bus.out), 0);
        drop_last();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(OP_DST, -999, 0, 0, -990, "post_reset");
        wait_drain();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
